round_controller: RTL and testbench

- Round sequencer that sits directly upstream of the two player FSMs.
- Collects one action per player per round through valid/ready handshakes and substitutes await (3'b010) for a player who times out.
- Drives action1/action2 with an actionEnable pulse wide enough for the players' rearm-on-low scheme.
- Monitors both health outputs to raise isGameOver and report the winner.

---
 rtl/round_controller.sv | 164 ++++++++++++++++
 tb/tb_round_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// round_controller: per-round sequencer feeding the two player FSMs.
// Collects one action per player over valid/ready, substitutes await on
// timeout, issues both actions with an actionEnable pulse, then checks
// health to detect the end of the game.
// Optional build macro: ROUND_LIMIT_EN ends the game after MAX_ROUNDS
// rounds, awarding the win to the healthier player.
module round_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ENABLE_CYCLES  = 2,
    parameter int ROUND_W        = 8,
    parameter int MAX_ROUNDS     = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_valid,
    input  logic [2:0]         p1_action,
    output logic               p1_ready,
    input  logic               p2_valid,
    input  logic [2:0]         p2_action,
    output logic               p2_ready,
    input  logic [1:0]         health1,
    input  logic [1:0]         health2,
    output logic [2:0]         action1,
    output logic [2:0]         action2,
    output logic               actionEnable,
    output logic               isGameOver,
    output logic [1:0]         winner,
    output logic [ROUND_W-1:0] round_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] EN_LAST    = EW'(ENABLE_CYCLES - 1);
    localparam logic [2:0]    AWAIT      = 3'b010;

    // Reject illegal configurations at elaboration time.
    if (TIMEOUT_CYCLES < 2 || ENABLE_CYCLES < 1 || MAX_ROUNDS < 1) begin : g_bad_params
        $error("round_controller: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE, COLLECT, ISSUE, SETTLE, CHECK, OVER
    } state_t;

    state_t             state, state_n;
    logic [TW-1:0]      timer, timer_n;
    logic [EW-1:0]      en_cnt, en_cnt_n;
    logic               cap1, cap1_n, cap2, cap2_n;
    logic [2:0]         act1_n, act2_n;
    logic [1:0]         winner_n;
    logic [ROUND_W-1:0] rc_n;
    logic               hs1, hs2;

`ifdef ROUND_LIMIT_EN
    localparam logic [ROUND_W:0] ROUND_LIMIT = (ROUND_W+1)'(MAX_ROUNDS);
    logic [ROUND_W:0] rc_plus1;
    assign rc_plus1 = {1'b0, round_count} + (ROUND_W+1)'(1);
`endif

    // Ready depends only on registered state so it never loops through valid.
    assign p1_ready     = (state == COLLECT) && !cap1;
    assign p2_ready     = (state == COLLECT) && !cap2;
    assign hs1          = p1_valid && p1_ready;
    assign hs2          = p2_valid && p2_ready;
    assign actionEnable = (state == ISSUE);
    assign isGameOver   = (state == OVER);

    // Next-state and datapath updates for every round phase.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        en_cnt_n = en_cnt;
        cap1_n   = cap1;
        cap2_n   = cap2;
        act1_n   = action1;
        act2_n   = action2;
        winner_n = winner;
        rc_n     = round_count;
        case (state)
            IDLE: state_n = COLLECT;
            COLLECT: begin
                timer_n = timer + TW'(1);
                if (hs1) begin
                    cap1_n = 1'b1;
                    act1_n = p1_action;
                end
                if (hs2) begin
                    cap2_n = 1'b1;
                    act2_n = p2_action;
                end
                // Captures on the timeout edge still count.
                if ((cap1_n && cap2_n) || (timer == TIMER_LAST)) begin
                    state_n  = ISSUE;
                    en_cnt_n = '0;
                    if (!cap1_n) act1_n = AWAIT;
                    if (!cap2_n) act2_n = AWAIT;
                end
            end
            ISSUE: begin
                en_cnt_n = en_cnt + EW'(1);
                if (en_cnt == EN_LAST) state_n = SETTLE;
            end
            // One low cycle lets the players rearm before health is read.
            SETTLE: state_n = CHECK;
            CHECK: begin
                if (health1 == 2'b00 && health2 == 2'b00) begin
                    winner_n = 2'b11;
                    state_n  = OVER;
                end else if (health2 == 2'b00) begin
                    winner_n = 2'b01;
                    state_n  = OVER;
                end else if (health1 == 2'b00) begin
                    winner_n = 2'b10;
                    state_n  = OVER;
                end else begin
                    timer_n = '0;
                    cap1_n  = 1'b0;
                    cap2_n  = 1'b0;
                    state_n = COLLECT;
                    rc_n    = (round_count == '1) ? round_count
                                                  : round_count + ROUND_W'(1);
`ifdef ROUND_LIMIT_EN
                    if (rc_plus1 == ROUND_LIMIT) begin
                        rc_n    = ROUND_W'(MAX_ROUNDS);
                        state_n = OVER;
                        if (health1 > health2)      winner_n = 2'b01;
                        else if (health2 > health1) winner_n = 2'b10;
                        else                        winner_n = 2'b11;
                    end
`endif
                end
            end
            OVER: ;
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            en_cnt      <= '0;
            cap1        <= 1'b0;
            cap2        <= 1'b0;
            action1     <= AWAIT;
            action2     <= AWAIT;
            winner      <= 2'b00;
            round_count <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            en_cnt      <= en_cnt_n;
            cap1        <= cap1_n;
            cap2        <= cap2_n;
            action1     <= act1_n;
            action2     <= act2_n;
            winner      <= winner_n;
            round_count <= rc_n;
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller; inputs driven and outputs sampled
// on the falling edge.
module tb_round_controller;

`ifdef ROUND_LIMIT_EN
    localparam int MAXR = 3;
`else
    localparam int MAXR = 20;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [2:0] p1_action = 3'b000, p2_action = 3'b000;
    logic       p1_ready, p2_ready;
    logic [1:0] health1 = 2'b11, health2 = 2'b11;
    logic [2:0] action1, action2;
    logic       actionEnable, isGameOver;
    logic [1:0] winner;
    logic [7:0] round_count;

    int checks = 0;
    int failures = 0;

    round_controller #(
        .TIMEOUT_CYCLES(16), .ENABLE_CYCLES(2), .ROUND_W(8), .MAX_ROUNDS(MAXR)
    ) dut (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_action(p1_action), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_action(p2_action), .p2_ready(p2_ready),
        .health1(health1), .health2(health2),
        .action1(action1), .action2(action2),
        .actionEnable(actionEnable), .isGameOver(isGameOver),
        .winner(winner), .round_count(round_count)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance to a negedge where both players are ready (fresh COLLECT).
    task automatic wait_collect();
        int n = 0;
        while (!(p1_ready && p2_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(p1_ready && p2_ready)) begin
            failures++;
            $display("FAIL wait_collect: no COLLECT within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({action1, action2, actionEnable, isGameOver, winner, round_count, p1_ready, p2_ready}
            !== {3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: a1=%b a2=%b en=%b over=%b win=%b rc=%0d rdy=%b%b want a1=010 a2=010 rest 0",
                     action1, action2, actionEnable, isGameOver, winner, round_count, p1_ready, p2_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (!(p1_ready && p2_ready)) begin
            failures++;
            $display("FAIL reset_to_collect: rdy=%b%b want 11", p1_ready, p2_ready);
        end
    endtask

    task automatic test_both_first_cycle();
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b110;
        p2_valid = 1'b1; p2_action = 3'b000;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        checks++;
        if (!(actionEnable === 1'b1 && action1 === 3'b110 && action2 === 3'b000)) begin
            failures++;
            $display("FAIL both_issue1: en=%b a1=%b a2=%b want en=1 a1=110 a2=000", actionEnable, action1, action2);
        end
        @(negedge clk);
        checks++;
        if (!(actionEnable === 1'b1 && action1 === 3'b110 && action2 === 3'b000)) begin
            failures++;
            $display("FAIL both_issue2: en=%b a1=%b a2=%b want en=1 a1=110 a2=000", actionEnable, action1, action2);
        end
        @(negedge clk);
        checks++;
        if (actionEnable !== 1'b0) begin
            failures++;
            $display("FAIL both_settle: en=%b want 0", actionEnable);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!(p1_ready && p2_ready && round_count === 8'd1)) begin
            failures++;
            $display("FAIL both_next_round: rdy=%b%b rc=%0d want rdy=11 rc=1", p1_ready, p2_ready, round_count);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b001;
        while (p2_ready && n < 100) begin
            @(negedge clk);
            p1_valid = 1'b0;
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL timeout_len: collect cycles=%0d want 16", n);
        end
        checks++;
        if (!(actionEnable === 1'b1 && action1 === 3'b001 && action2 === 3'b010)) begin
            failures++;
            $display("FAIL timeout_issue: en=%b a1=%b a2=%b want en=1 a1=001 a2=010", actionEnable, action1, action2);
        end
        wait_collect();
        checks++;
        if (round_count !== 8'd2) begin
            failures++;
            $display("FAIL timeout_rc: rc=%0d want 2", round_count);
        end
    endtask

    task automatic test_timeout_edge();
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b011;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            p1_valid = 1'b0;
        end
        checks++;
        if (p2_ready !== 1'b1 || actionEnable !== 1'b0) begin
            failures++;
            $display("FAIL edge_ready: p2_ready=%b en=%b want 1 0", p2_ready, actionEnable);
        end
        p2_valid = 1'b1; p2_action = 3'b100;
        @(negedge clk);
        p2_valid = 1'b0;
        checks++;
        if (!(actionEnable === 1'b1 && action1 === 3'b011 && action2 === 3'b100)) begin
            failures++;
            $display("FAIL edge_accept: en=%b a1=%b a2=%b want en=1 a1=011 a2=100", actionEnable, action1, action2);
        end
    endtask

    task automatic test_second_offer();
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b101;
        @(negedge clk);
        p1_action = 3'b111;
        checks++;
        if (p1_ready !== 1'b0 || p2_ready !== 1'b1) begin
            failures++;
            $display("FAIL second_ready: rdy=%b%b want 01", p1_ready, p2_ready);
        end
        p2_valid = 1'b1; p2_action = 3'b110;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        checks++;
        if (!(actionEnable === 1'b1 && action1 === 3'b101 && action2 === 3'b110)) begin
            failures++;
            $display("FAIL second_hold: en=%b a1=%b a2=%b want en=1 a1=101 a2=110", actionEnable, action1, action2);
        end
        wait_collect();
        checks++;
        if (round_count !== 8'd4) begin
            failures++;
            $display("FAIL second_rc: rc=%0d want 4", round_count);
        end
    endtask

    task automatic test_game_over();
        health1 = 2'b11; health2 = 2'b11;
        apply_reset();
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b000;
        p2_valid = 1'b1; p2_action = 3'b001;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        health2 = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (!(isGameOver === 1'b1 && winner === 2'b01 && round_count === 8'd0 && actionEnable === 1'b0)) begin
            failures++;
            $display("FAIL over_p1: over=%b win=%b rc=%0d en=%b want 1 01 0 0", isGameOver, winner, round_count, actionEnable);
        end
        p1_valid = 1'b1; p1_action = 3'b111;
        p2_valid = 1'b1; p2_action = 3'b111;
        health1 = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (!(p1_ready === 1'b0 && p2_ready === 1'b0 && action1 === 3'b000 && action2 === 3'b001
              && isGameOver === 1'b1 && winner === 2'b01)) begin
            failures++;
            $display("FAIL over_frozen: rdy=%b%b a1=%b a2=%b over=%b win=%b want 00 000 001 1 01",
                     p1_ready, p2_ready, action1, action2, isGameOver, winner);
        end
        apply_reset();
        wait_collect();
        p1_valid = 1'b1; p2_valid = 1'b1;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!(isGameOver === 1'b1 && winner === 2'b11)) begin
            failures++;
            $display("FAIL over_draw: over=%b win=%b want 1 11", isGameOver, winner);
        end
        health1 = 2'b11; health2 = 2'b11;
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        wait_collect();
        p1_valid = 1'b1; p1_action = 3'b110;
        p2_valid = 1'b1; p2_action = 3'b001;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (!(actionEnable === 1'b0 && action1 === 3'b010 && action2 === 3'b010
              && p1_ready === 1'b0 && p2_ready === 1'b0 && isGameOver === 1'b0)) begin
            failures++;
            $display("FAIL mid_issue_reset: en=%b a1=%b a2=%b rdy=%b%b want 0 010 010 00",
                     actionEnable, action1, action2, p1_ready, p2_ready);
        end
        @(negedge clk);
        checks++;
        if (!(p1_ready && p2_ready && round_count === 8'd0)) begin
            failures++;
            $display("FAIL mid_issue_idle_exit: rdy=%b%b rc=%0d want 11 0", p1_ready, p2_ready, round_count);
        end
    endtask

`ifdef ROUND_LIMIT_EN
    task automatic test_round_limit();
        health1 = 2'b11; health2 = 2'b10;
        apply_reset();
        for (int r = 1; r <= 3; r++) begin
            wait_collect();
            p1_valid = 1'b1; p2_valid = 1'b1;
            @(negedge clk);
            p1_valid = 1'b0; p2_valid = 1'b0;
            repeat (4) @(negedge clk);
            checks++;
            if (round_count !== 8'(r) || isGameOver !== (r == 3)) begin
                failures++;
                $display("FAIL limit_round%0d: rc=%0d over=%b want rc=%0d over=%0d",
                         r, round_count, isGameOver, r, (r == 3));
            end
        end
        checks++;
        if (winner !== 2'b01) begin
            failures++;
            $display("FAIL limit_winner: win=%b want 01", winner);
        end
        health1 = 2'b11; health2 = 2'b11;
    endtask
`endif

    initial begin
        test_reset();
`ifdef ROUND_LIMIT_EN
        test_round_limit();
`else
        test_both_first_cycle();
        test_timeout();
        test_timeout_edge();
        test_second_offer();
`endif
        test_game_over();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
